// File: rtl/mouse_grid_picker_if.sv
// rtl/mouse_grid_picker_if.sv - mouse position/button inputs and picked-cell outputs of the grid picker
interface mouse_grid_picker_if #(
   parameter int COORD_W = 12
);
   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic               mouse_left;
   logic [7:0]         mouse_pos;
   logic [6:0]         ship_xy;
   logic               cell_valid;
   logic               pick_ship;

   modport master (
      output xpos, ypos, mouse_left,
      input  mouse_pos, ship_xy, cell_valid, pick_ship
   );

   modport slave (
      input  xpos, ypos, mouse_left,
      output mouse_pos, ship_xy, cell_valid, pick_ship
   );
endinterface

// File: rtl/mouse_grid_picker.sv
// rtl/mouse_grid_picker.sv - converts mouse pixels to a board cell and a left press to a one-cycle pick
// Conversion runs continuously: IDLE, SAMPLE, GRID_N division steps, DONE.
module mouse_grid_picker #(
   parameter int BOARD_X0  = 64,
   parameter int BOARD_Y0  = 64,
   parameter int CELL_SIZE = 36,
   parameter int GRID_N    = 10,
   parameter int COORD_W   = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   mouse_grid_picker_if.slave bus
);
   localparam int CNT_W = 5;
   localparam logic [COORD_W-1:0] X_LO = COORD_W'(BOARD_X0);
   localparam logic [COORD_W-1:0] X_HI = COORD_W'(BOARD_X0 + GRID_N * CELL_SIZE - 1);
   localparam logic [COORD_W-1:0] Y_LO = COORD_W'(BOARD_Y0);
   localparam logic [COORD_W-1:0] Y_HI = COORD_W'(BOARD_Y0 + GRID_N * CELL_SIZE - 1);
   localparam logic [COORD_W-1:0] CELL = COORD_W'(CELL_SIZE);
   localparam logic [CNT_W-1:0]   LAST = CNT_W'(GRID_N - 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, DIV, DONE} state_t;
   state_t state, state_nxt;

   logic               sync1, sync2, sync3;
   logic               rise;
   logic               pend;
   logic               take_pick;
   logic               in_r;
   logic               in_board;
   logic [COORD_W-1:0] xr, yr;
   logic [3:0]         col, row;
   logic [CNT_W-1:0]   cnt;
   logic [7:0]         mouse_pos_r;
   logic [6:0]         ship_xy_r;
   logic               cell_valid_r;
   logic               pick_ship_r;
   logic [7:0]         xy_full;

   assign rise     = sync2 & ~sync3;
   assign in_board = (bus.xpos >= X_LO) && (bus.xpos <= X_HI) &&
                     (bus.ypos >= Y_LO) && (bus.ypos <= Y_HI);
   assign xy_full  = {4'd0, row} * 8'(GRID_N) + {4'd0, col};

   assign bus.mouse_pos  = mouse_pos_r;
   assign bus.ship_xy    = ship_xy_r;
   assign bus.cell_valid = cell_valid_r;
   assign bus.pick_ship  = pick_ship_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = SAMPLE;
         SAMPLE:  state_nxt = in_board ? DIV : DONE;
         DIV:     state_nxt = (cnt == LAST) ? DONE : DIV;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         sync3        <= 1'b0;
         pend         <= 1'b0;
         take_pick    <= 1'b0;
         in_r         <= 1'b0;
         xr           <= '0;
         yr           <= '0;
         col          <= '0;
         row          <= '0;
         cnt          <= '0;
         mouse_pos_r  <= '0;
         ship_xy_r    <= '0;
         cell_valid_r <= 1'b0;
         pick_ship_r  <= 1'b0;
      end else begin
         sync1       <= bus.mouse_left;
         sync2       <= sync1;
         sync3       <= sync2;
         pick_ship_r <= 1'b0;
         // SAMPLE consumes the pending press, but an edge arriving in that same cycle survives
         if (state == SAMPLE) pend <= rise;
         else if (rise)       pend <= 1'b1;
         case (state)
            SAMPLE: begin
               take_pick <= pend;
               in_r      <= in_board;
               cnt       <= '0;
               if (in_board) begin
                  xr  <= bus.xpos - X_LO;
                  yr  <= bus.ypos - Y_LO;
                  col <= '0;
                  row <= '0;
               end
            end
            DIV: begin
               cnt <= cnt + 1'b1;
               if (xr >= CELL) begin
                  xr  <= xr - CELL;
                  col <= col + 4'd1;
               end
               if (yr >= CELL) begin
                  yr  <= yr - CELL;
                  row <= row + 4'd1;
               end
            end
            DONE: begin
               cell_valid_r <= in_r;
               pick_ship_r  <= take_pick & in_r;
               if (in_r) begin
                  mouse_pos_r <= {row, col};
                  ship_xy_r   <= xy_full[6:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mouse_grid_picker.sv
// tb/tb_mouse_grid_picker.sv - directed self-checking bench for mouse_grid_picker
module tb_mouse_grid_picker;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   npulse;
   int   viol;
   logic prev_pick;

   mouse_grid_picker_if #(.COORD_W(12)) bus ();

   mouse_grid_picker dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (bus.pick_ship === 1'b1) begin
         npulse++;
         if (prev_pick === 1'b1) viol++;
         if (bus.cell_valid !== 1'b1) viol++;
      end
      prev_pick = bus.pick_ship;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic clear_stats();
      npulse = 0;
      viol   = 0;
   endtask

   task automatic press();
      bus.mouse_left = 1'b1;
      run(3);
      bus.mouse_left = 1'b0;
      run(40);
   endtask

   task automatic wait_pulse(input string tag);
      int k;
      k = 0;
      cyc();
      while (bus.pick_ship !== 1'b1 && k < 60) begin
         cyc();
         k++;
      end
      check(tag, 32'(bus.pick_ship), 32'd1);
   endtask

   task automatic set_pos(input int x, input int y);
      bus.xpos = 12'(x);
      bus.ypos = 12'(y);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      prev_pick = 1'b0;
      clear_stats();
      rst_n          = 1'b0;
      bus.mouse_left = 1'b0;
      set_pos(0, 0);
      run(4);
      check("rst_mouse_pos", 32'(bus.mouse_pos), 32'h00);
      check("rst_ship_xy", 32'(bus.ship_xy), 32'd0);
      check("rst_cell_valid", 32'(bus.cell_valid), 32'd0);
      check("rst_pick", 32'(bus.pick_ship), 32'd0);
      rst_n = 1'b1;
      run(5);

      // top-left cell
      set_pos(64, 64);
      run(30);
      clear_stats();
      press();
      check("tl_pulses", 32'(npulse), 32'd1);
      check("tl_mouse_pos", 32'(bus.mouse_pos), 32'h00);
      check("tl_ship_xy", 32'(bus.ship_xy), 32'd0);
      check("tl_cell_valid", 32'(bus.cell_valid), 32'd1);

      // bottom-right cell, then one pixel past the edge
      set_pos(423, 423);
      run(30);
      clear_stats();
      press();
      check("br_pulses", 32'(npulse), 32'd1);
      check("br_mouse_pos", 32'(bus.mouse_pos), 32'h99);
      check("br_ship_xy", 32'(bus.ship_xy), 32'd99);
      set_pos(424, 423);
      run(30);
      check("out_cell_valid", 32'(bus.cell_valid), 32'd0);
      check("out_hold_pos", 32'(bus.mouse_pos), 32'h99);
      clear_stats();
      press();
      check("out_pulses", 32'(npulse), 32'd0);
      check("out_hold_xy", 32'(bus.ship_xy), 32'd99);

      // just below a cell boundary in x, two cells down in y
      set_pos(99, 136);
      run(30);
      clear_stats();
      press();
      check("mid_pulses", 32'(npulse), 32'd1);
      check("mid_mouse_pos", 32'(bus.mouse_pos), 32'h20);
      check("mid_ship_xy", 32'(bus.ship_xy), 32'd20);
      check("mid_cell_valid", 32'(bus.cell_valid), 32'd1);

      // sweep without pressing
      clear_stats();
      set_pos(64 + 3*36 + 5, 64 + 1*36 + 5);
      run(30);
      check("sweep_13", 32'(bus.ship_xy), 32'd13);
      check("sweep_13_pos", 32'(bus.mouse_pos), 32'h13);
      set_pos(64 + 7*36 + 35, 64 + 5*36);
      run(30);
      check("sweep_57", 32'(bus.ship_xy), 32'd57);
      set_pos(64, 64 + 9*36 + 20);
      run(30);
      check("sweep_90", 32'(bus.ship_xy), 32'd90);
      check("sweep_90_pos", 32'(bus.mouse_pos), 32'h90);
      check("sweep_pulses", 32'(npulse), 32'd0);

      // button held for 200 cycles
      set_pos(64, 64);
      run(30);
      clear_stats();
      bus.mouse_left = 1'b1;
      run(200);
      bus.mouse_left = 1'b0;
      run(40);
      check("hold_pulses", 32'(npulse), 32'd1);
      check("hold_viol", 32'(viol), 32'd0);

      // three presses inside one conversion, launched right after a pick
      bus.mouse_left = 1'b1;
      run(3);
      bus.mouse_left = 1'b0;
      wait_pulse("align_pulse");
      clear_stats();
      bus.mouse_left = 1'b1; run(1);
      bus.mouse_left = 1'b0; run(1);
      bus.mouse_left = 1'b1; run(1);
      bus.mouse_left = 1'b0; run(1);
      bus.mouse_left = 1'b1; run(1);
      bus.mouse_left = 1'b0; run(40);
      check("burst_pulses", 32'(npulse), 32'd1);
      check("burst_viol", 32'(viol), 32'd0);

      // reset mid-DIV with a pending press
      set_pos(99, 136);
      run(30);
      bus.mouse_left = 1'b1;
      run(3);
      bus.mouse_left = 1'b0;
      wait_pulse("pre_rst_pulse");
      bus.mouse_left = 1'b1;
      run(5);
      bus.mouse_left = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_mouse_pos", 32'(bus.mouse_pos), 32'h00);
      check("arst_ship_xy", 32'(bus.ship_xy), 32'd0);
      check("arst_cell_valid", 32'(bus.cell_valid), 32'd0);
      check("arst_pick", 32'(bus.pick_ship), 32'd0);
      run(3);
      rst_n = 1'b1;
      clear_stats();
      run(40);
      check("arst_no_pulse", 32'(npulse), 32'd0);
      check("arst_reconv_valid", 32'(bus.cell_valid), 32'd1);
      check("arst_reconv_pos", 32'(bus.mouse_pos), 32'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
